instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Front end of the single-cycle RISC-V core that produces the instruction stream consumed by the instruction decoder. It holds the program counter and issues word fetches to instruction memory over a valid/ready request plus valid response interface. It hands each fetched instruction and its address to decode through a one-entry valid/ready output register. Taken jumps and branches from execute redirect the PC and flush any in-flight or buffered instruction.

Parameters:
ENTRY_ADDRESS, 32'h0000_1000, PC value after reset.
MAX_WAIT, 255, response timeout in cycles; width of wait counter is 8 bits.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
io_jump_flag  in  1  redirect request from execute, sampled every cycle
io_jump_address  in  32  redirect target
io_mem_req_valid  out  1  fetch request valid
io_mem_req_ready  in  1  memory accepts request
io_mem_req_address  out  32  word address of request, bits[1:0]=0
io_mem_resp_valid  in  1  response valid, exactly one per accepted request, at least 1 cycle after accept
io_mem_resp_data  in  32  instruction word
io_instruction_valid  out  1  output register holds an instruction
io_instruction_ready  in  1  decode consumes instruction
io_instruction  out  32  instruction to decoder
io_instruction_address  out  32  address of io_instruction
io_fetch_timeout  out  1  sticky: response exceeded MAX_WAIT cycles

Behaviour:
- Reset (async, immediate): pc=ENTRY_ADDRESS, state=REQ, io_instruction_valid=0, io_instruction=32'h0000_0013 (NOP), io_instruction_address=0, io_mem_req_valid=0 while reset is asserted, io_fetch_timeout=0, wait counter=0.
- States: REQ, WAIT, FULL, DROP.
- REQ: io_mem_req_valid=1, io_mem_req_address=pc. When req_ready=1: latch req_addr=pc, set pc=pc+4 (mod 2^32), go to WAIT.
- WAIT: req_valid=0. On resp_valid: io_instruction<=resp_data, io_instruction_address<=req_addr, valid<=1, go to FULL. Minimum latency is 2 cycles from request accept to valid.
- FULL: req_valid=0, valid=1, and outputs hold stable. When valid&ready: valid<=0, go to REQ. At most one instruction is outstanding or buffered, so sustained throughput is one instruction per 3 cycles with 1-cycle memory.
- DROP: one request is in flight with a stale address. The next resp_valid is discarded, then go to REQ. req_valid=0.
- Jump (io_jump_flag=1) has priority over all other events in the same cycle:
  - pc<=io_jump_address with bits[1:0] forced to 0.
  - valid<=0, and the buffered instruction is discarded even if ready=1 that cycle.
  - REQ with req_ready=1 (request accepted this cycle) -> DROP. REQ without accept -> REQ (new address next cycle).
  - WAIT without resp -> DROP. WAIT with resp the same cycle -> resp discarded, go to REQ.
  - FULL -> REQ. DROP without resp -> DROP. DROP with resp -> REQ.
- Wait counter: cleared on entering WAIT/DROP, incremented each cycle in WAIT/DROP without resp, saturating at MAX_WAIT. Reaching MAX_WAIT sets io_fetch_timeout, which stays set until reset. The state is unchanged and the unit keeps waiting.
- resp_valid in REQ or FULL is a protocol violation and is ignored.
- io_instruction retains its last value when valid=0.

Optional Feature:
Macro IFETCH_PERF_COUNTERS_EN.
- Defined: adds outputs io_fetched_count (32), counting instructions delivered (valid&ready with no jump), and io_flushed_count (32), counting discarded instructions (buffered at jump, or responses dropped). Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and logic are absent and other behaviour is identical.

Test Plan:
- Reset release, memory ready=1, 1-cycle resp returning 0x00500093, decode ready=1 -> first request address 0x1000; valid 2 cycles after accept with instruction 0x00500093 and address 0x1000; next request address 0x1004.
- Decode ready=0 for 5 cycles while FULL -> outputs stable, no new request; ready=1 -> consumed, request at next pc.
- Jump to 0x2002 in WAIT, resp arrives 3 cycles later -> resp discarded, next request 0x2000, delivered address 0x2000; flushed_count=1 when the feature is enabled.
- Jump to 0x3000 in the same cycle as resp_valid in WAIT -> no valid raised, request 0x3000 issued the next cycle.
- Jump while FULL with ready=1 -> instruction not counted as delivered, valid=0 next cycle.
- Memory never responds -> io_fetch_timeout=1 after 255 cycles in WAIT; reset asserted mid-WAIT -> immediate return to REQ at 0x1000 with timeout cleared.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, single-outstanding fetch to instruction
// memory (valid/ready request, valid response) and a one-entry output
// register towards decode. Jumps from execute redirect the PC and flush any
// in-flight or buffered instruction.
// Optional build macro: IFETCH_PERF_COUNTERS_EN adds the delivered/flushed
// instruction counters io_fetched_count and io_flushed_count.
module instruction_fetch #(
    parameter logic [31:0] ENTRY_ADDRESS = 32'h0000_1000,
    parameter int unsigned MAX_WAIT      = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_jump_flag,
    input  logic [31:0] io_jump_address,
    output logic        io_mem_req_valid,
    input  logic        io_mem_req_ready,
    output logic [31:0] io_mem_req_address,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_data,
    output logic        io_instruction_valid,
    input  logic        io_instruction_ready,
    output logic [31:0] io_instruction,
    output logic [31:0] io_instruction_address,
    output logic        io_fetch_timeout
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] io_fetched_count,
    output logic [31:0] io_flushed_count
`endif
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [7:0]  WAIT_MAX  = 8'(MAX_WAIT);
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_FULL,
        ST_DROP
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] instr_q;
    logic [31:0] instr_addr_q;
    logic        instr_valid_q;
    logic        timeout_q;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_cnt_d;
    logic        wait_hit;
    logic [31:0] jump_pc;

    // Saturating increment of the response wait counter and its timeout tap
    always_comb begin
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
        wait_hit   = (wait_cnt_q >= WAIT_LAST);
        jump_pc    = {io_jump_address[31:2], 2'b00};
    end

    // Request is only offered in REQ; forced low while reset is held
    assign io_mem_req_valid       = (state_q == ST_REQ) && !reset;
    assign io_mem_req_address     = pc_q;
    assign io_instruction         = instr_q;
    assign io_instruction_address = instr_addr_q;
    assign io_instruction_valid   = instr_valid_q;
    assign io_fetch_timeout       = timeout_q;

    // Fetch FSM: a jump overrides every other event in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_REQ;
            pc_q          <= ENTRY_ADDRESS;
            req_addr_q    <= ENTRY_ADDRESS;
            instr_q       <= NOP;
            instr_addr_q  <= 32'h0;
            instr_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            wait_cnt_q    <= 8'h0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (io_jump_flag) begin
                        // An accepted request now carries a stale address
                        pc_q <= jump_pc;
                        if (io_mem_req_ready) begin
                            state_q    <= ST_DROP;
                            wait_cnt_q <= 8'h0;
                        end
                    end else if (io_mem_req_ready) begin
                        req_addr_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= 8'h0;
                    end
                end
                ST_WAIT: begin
                    if (io_jump_flag) begin
                        pc_q <= jump_pc;
                        if (io_mem_resp_valid) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q    <= ST_DROP;
                            wait_cnt_q <= 8'h0;
                        end
                    end else if (io_mem_resp_valid) begin
                        instr_q       <= io_mem_resp_data;
                        instr_addr_q  <= req_addr_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_FULL;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_hit) timeout_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (io_jump_flag) begin
                        pc_q          <= jump_pc;
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_REQ;
                    end else if (io_instruction_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_REQ;
                    end
                end
                default: begin  // ST_DROP
                    if (io_jump_flag) pc_q <= jump_pc;
                    if (io_mem_resp_valid) begin
                        state_q <= ST_REQ;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_hit) timeout_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_COUNTERS_EN
    logic        deliver_evt;
    logic        flush_evt;
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    // Delivered: consumed without a jump. Flushed: buffered at a jump, or a
    // response thrown away (stale in DROP, or racing a jump in WAIT).
    always_comb begin
        deliver_evt = (state_q == ST_FULL) && io_instruction_ready && !io_jump_flag;
        flush_evt   = ((state_q == ST_FULL) && io_jump_flag) ||
                      ((state_q == ST_WAIT) && io_jump_flag && io_mem_resp_valid) ||
                      ((state_q == ST_DROP) && io_mem_resp_valid);
    end

    // Free-running wrap-around event counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            if (deliver_evt) fetched_q <= fetched_q + 32'd1;
            if (flush_evt)   flushed_q <= flushed_q + 32'd1;
        end
    end

    assign io_fetched_count = fetched_q;
    assign io_flushed_count = flushed_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model (in-flight flag,
// stale flag, output buffer) predicts outputs checked every negedge, plus
// hand-computed literal checks along a directed scenario.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_jump_flag;
    logic [31:0] io_jump_address;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic [31:0] io_mem_req_address;
    logic        io_mem_resp_valid;
    logic [31:0] io_mem_resp_data;
    logic        io_instruction_valid;
    logic        io_instruction_ready;
    logic [31:0] io_instruction;
    logic [31:0] io_instruction_address;
    logic        io_fetch_timeout;
`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] io_fetched_count;
    logic [31:0] io_flushed_count;
`endif

    instruction_fetch dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_jump_flag          (io_jump_flag),
        .io_jump_address       (io_jump_address),
        .io_mem_req_valid      (io_mem_req_valid),
        .io_mem_req_ready      (io_mem_req_ready),
        .io_mem_req_address    (io_mem_req_address),
        .io_mem_resp_valid     (io_mem_resp_valid),
        .io_mem_resp_data      (io_mem_resp_data),
        .io_instruction_valid  (io_instruction_valid),
        .io_instruction_ready  (io_instruction_ready),
        .io_instruction        (io_instruction),
        .io_instruction_address(io_instruction_address),
        .io_fetch_timeout      (io_fetch_timeout)
`ifdef IFETCH_PERF_COUNTERS_EN
        ,
        .io_fetched_count      (io_fetched_count),
        .io_flushed_count      (io_flushed_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] m_pc, m_reqaddr, m_ins, m_insaddr, m_fetched, m_flushed;
    bit          m_inflight, m_stale, m_bufv, m_to;
    int          m_wcnt;

    task automatic model_reset();
        m_pc = 32'h1000; m_reqaddr = 32'h1000;
        m_ins = 32'h13; m_insaddr = 32'h0;
        m_inflight = 0; m_stale = 0; m_bufv = 0; m_to = 0; m_wcnt = 0;
        m_fetched = 0; m_flushed = 0;
    endtask

    task automatic bump();
        if (m_wcnt < 255) m_wcnt++;
        if (m_wcnt == 255) m_to = 1;
    endtask

    task automatic model_step(input bit j, input logic [31:0] ja, input bit acc,
                              input bit rsp, input logic [31:0] rd, input bit rdy);
        bit had;
        had = m_inflight;
        if (j) begin
            if (m_bufv) m_flushed++;
            m_bufv = 0;
            if (had && rsp) begin
                m_flushed++;
                m_inflight = 0;
            end else if (had) begin
                if (!m_stale) m_wcnt = 0; else bump();
                m_stale = 1;
            end
            if (acc) begin m_inflight = 1; m_stale = 1; m_wcnt = 0; end
            m_pc = {ja[31:2], 2'b00};
        end else if (m_bufv) begin
            if (rdy) begin m_bufv = 0; m_fetched++; end
        end else if (had) begin
            if (rsp) begin
                m_inflight = 0;
                if (m_stale) m_flushed++;
                else begin m_bufv = 1; m_ins = rd; m_insaddr = m_reqaddr; end
            end else bump();
        end else if (acc) begin
            m_inflight = 1; m_stale = 0; m_reqaddr = m_pc; m_pc = m_pc + 4; m_wcnt = 0;
        end
    endtask

    // Compare process: outputs against the model every cycle
    always @(negedge clock) begin
        logic exp_rv;
        exp_rv = !reset && !m_inflight && !m_bufv;
        chk("req_valid", io_mem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", io_mem_req_address, m_pc);
        chk("instr_valid", io_instruction_valid, m_bufv);
        chk("instr", io_instruction, m_ins);
        chk("instr_addr", io_instruction_address, m_insaddr);
        chk("timeout", io_fetch_timeout, m_to);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("fetched_cnt", io_fetched_count, m_fetched);
        chk("flushed_cnt", io_flushed_count, m_flushed);
`endif
    end

    // ---------------- memory + stimulus ----------------
    int          mem_lat;   // 0 = never respond
    int          pend;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h1000) ? 32'h0050_0093 : (a ^ 32'h5A5A_0013);
    endfunction

    task automatic cyc();
        bit j, acc, rsp, rdy;
        logic [31:0] ja, rd, ra;
        j = io_jump_flag; ja = io_jump_address;
        acc = io_mem_req_valid && io_mem_req_ready; ra = io_mem_req_address;
        rsp = io_mem_resp_valid; rd = io_mem_resp_data; rdy = io_instruction_ready;
        @(posedge clock);
        #1;
        model_step(j, ja, acc, rsp, rd, rdy);
        io_mem_resp_valid = 1'b0;
        if (acc) begin pend = mem_lat; pend_addr = ra; end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                io_mem_resp_valid = 1'b1;
                io_mem_resp_data  = mem_word(pend_addr);
            end
        end
    endtask

    task automatic run_until_valid(input int bound, input string nm);
        for (int i = 0; i < bound && !io_instruction_valid; i++) cyc();
        chk(nm, io_instruction_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        io_jump_flag = 1'b0; io_jump_address = 32'h0;
        io_mem_req_ready = 1'b1; io_mem_resp_valid = 1'b0; io_mem_resp_data = 32'h0;
        io_instruction_ready = 1'b1;
        mem_lat = 1; pend = 0; pend_addr = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_valid", io_mem_req_valid, 1'b0);
        chk("rst_instr", io_instruction, 32'h13);
        chk("rst_instr_addr", io_instruction_address, 32'h0);
        reset = 1'b0;
        #1;
        // first fetch, 1-cycle memory
        chk("t1_req_valid", io_mem_req_valid, 1'b1);
        chk("t1_req_addr", io_mem_req_address, 32'h1000);
        cyc();
        chk("t1_not_yet_valid", io_instruction_valid, 1'b0);
        cyc();
        chk("t1_valid", io_instruction_valid, 1'b1);
        chk("t1_instr", io_instruction, 32'h0050_0093);
        chk("t1_instr_addr", io_instruction_address, 32'h1000);
        cyc();
        chk("t1_next_req", io_mem_req_address, 32'h1004);
        // decode stall while FULL
        io_instruction_ready = 1'b0;
        run_until_valid(10, "t2_valid");
        repeat (5) cyc();
        chk("t2_hold_addr", io_instruction_address, 32'h1004);
        chk("t2_hold_instr", io_instruction, mem_word(32'h1004));
        chk("t2_no_req", io_mem_req_valid, 1'b0);
        io_instruction_ready = 1'b1;
        cyc();
        chk("t2_next_req", io_mem_req_address, 32'h1008);
        // jump in WAIT, stale response 3 cycles after accept
        mem_lat = 3;
        cyc();
        io_jump_flag = 1'b1; io_jump_address = 32'h2002;
        cyc();
        io_jump_flag = 1'b0;
        cyc();
        cyc();
        chk("t3_req_valid", io_mem_req_valid, 1'b1);
        chk("t3_req_addr", io_mem_req_address, 32'h2000);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("t3_flushed", io_flushed_count, 32'd1);
`endif
        mem_lat = 1;
        run_until_valid(10, "t3_valid");
        chk("t3_instr_addr", io_instruction_address, 32'h2000);
        cyc();
        // jump coincident with response in WAIT
        cyc();
        io_jump_flag = 1'b1; io_jump_address = 32'h3000;
        cyc();
        io_jump_flag = 1'b0;
        chk("t4_no_valid", io_instruction_valid, 1'b0);
        chk("t4_req_valid", io_mem_req_valid, 1'b1);
        chk("t4_req_addr", io_mem_req_address, 32'h3000);
        // jump while FULL with ready=1
        run_until_valid(10, "t5_valid");
        io_jump_flag = 1'b1; io_jump_address = 32'h4000;
        cyc();
        io_jump_flag = 1'b0;
        chk("t5_valid_drop", io_instruction_valid, 1'b0);
        chk("t5_req_addr", io_mem_req_address, 32'h4000);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("t5_fetched", io_fetched_count, 32'd3);
        chk("t5_flushed", io_flushed_count, 32'd3);
`endif
        // memory never answers -> timeout after 255 waiting cycles
        mem_lat = 0;
        cyc();
        repeat (254) cyc();
        chk("t6_timeout_254", io_fetch_timeout, 1'b0);
        cyc();
        chk("t6_timeout_255", io_fetch_timeout, 1'b1);
        repeat (3) cyc();
        chk("t6_timeout_sticky", io_fetch_timeout, 1'b1);
        // async reset mid-WAIT
        #2;
        reset = 1'b1;
        model_reset();
        pend = 0; io_mem_resp_valid = 1'b0;
        #1;
        chk("t6_rst_timeout", io_fetch_timeout, 1'b0);
        chk("t6_rst_req_valid", io_mem_req_valid, 1'b0);
        chk("t6_rst_instr", io_instruction, 32'h13);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_req_valid", io_mem_req_valid, 1'b1);
        chk("t6_req_addr", io_mem_req_address, 32'h1000);
        mem_lat = 1;
        run_until_valid(10, "t6_valid");
        chk("t6_instr", io_instruction, 32'h0050_0093);
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
